// File: rtl/pixel_pkg.sv
// Shared types and lane helpers for the pixel packer and its companion unpacker.
package pixel_pkg;

    localparam int PIXEL_W = 16;
    localparam int WORD_W  = 128;
    localparam int LANES   = WORD_W / PIXEL_W;
    localparam int IDX_W   = $clog2(LANES);

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [IDX_W-1:0]   lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Lanes below idx come from the accumulator, lane idx takes the new pixel, lanes above are padded.
    function automatic word_t merge_lanes(input word_t acc, input pixel_t pix,
                                          input lane_idx_t idx, input pixel_t pad);
        word_t w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l < int'(idx)) begin
                w[l*PIXEL_W +: PIXEL_W] = acc[l*PIXEL_W +: PIXEL_W];
            end else if (l == int'(idx)) begin
                w[l*PIXEL_W +: PIXEL_W] = pix;
            end else begin
                w[l*PIXEL_W +: PIXEL_W] = pad;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// Pixel input stream plus packed AXI-Stream output of the packer, with the packer's and its environment's views.
interface pixel_word_packer_if;
    import pixel_pkg::*;

    logic   pixel_valid;
    logic   pixel_ready;
    pixel_t pixel_data;
    logic   pixel_last;
    logic   m_axis_tvalid;
    logic   m_axis_tready;
    word_t  m_axis_tdata;
    logic   m_axis_tlast;
    logic   m_axis_prog_full;

    modport master (
        input  pixel_valid, pixel_data, pixel_last, m_axis_tready, m_axis_prog_full,
        output pixel_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        output pixel_valid, pixel_data, pixel_last, m_axis_tready, m_axis_prog_full,
        input  pixel_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: holds data/last stable until the send handshake.
module axis_out_reg
    import pixel_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t load_data,
    input  logic  load_last,
    input  logic  tready,
    output logic  can_load,
    output logic  send,
    output logic  tvalid,
    output word_t tdata,
    output logic  tlast
);

    out_state_e state_r;
    out_state_e state_s;
    word_t      data_r;
    logic       last_r;
    logic       load_ok_s;

    assign tvalid    = (state_r == FULL);
    assign can_load  = !tvalid || tready;
    assign load_ok_s = load && can_load;
    assign send      = tvalid && tready;
    assign tdata     = data_r;
    assign tlast     = last_r;

    // State, data and last registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            data_r  <= '0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_ok_s) begin
                data_r <= load_data;
                last_r <= load_last;
            end
        end
    end

    // Next state: a load always leaves the register full, a send without a load empties it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (load_ok_s) begin
                    state_s = FULL;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                if (load_ok_s) begin
                    state_s = FULL;
                end else if (tready) begin
                    state_s = EMPTY;
                end else begin
                    state_s = FULL;
                end
            end
            default: state_s = EMPTY;
        endcase
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs 16-bit pixels into 128-bit AXI-Stream words, padding the last word of each frame.
module pixel_word_packer
    import pixel_pkg::*;
#(
    parameter pixel_t PAD_VALUE   = 16'h0000,
    parameter int     FRAME_CNT_W = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    pixel_word_packer_if.master    bus,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [15:0]            word_count
);

    lane_idx_t              idx_r;
    word_t                  acc_r;
    logic [FRAME_CNT_W-1:0] frame_count_r;
    logic [15:0]            word_count_r;

    logic  can_load_s;
    logic  send_s;
    logic  pixel_ready_s;
    logic  accept_s;
    logic  complete_s;
    word_t merged_s;

    // prog_full may only hold back the first pixel of a word; a started word is always finished.
    assign pixel_ready_s = !rst_in && can_load_s && !((idx_r == '0) && bus.m_axis_prog_full);
    assign accept_s      = bus.pixel_valid && pixel_ready_s;
    assign complete_s    = accept_s && ((idx_r == LAST_LANE) || bus.pixel_last);
    assign merged_s      = merge_lanes(acc_r, bus.pixel_data, idx_r, PAD_VALUE);

    assign bus.pixel_ready = pixel_ready_s;
    assign frame_count     = frame_count_r;
    assign word_count      = word_count_r;

    axis_out_reg u_out (
        .clk       (clk_in),
        .rst       (rst_in),
        .load      (complete_s),
        .load_data (merged_s),
        .load_last (bus.pixel_last),
        .tready    (bus.m_axis_tready),
        .can_load  (can_load_s),
        .send      (send_s),
        .tvalid    (bus.m_axis_tvalid),
        .tdata     (bus.m_axis_tdata),
        .tlast     (bus.m_axis_tlast)
    );

    // Lane index and accumulator of the word being assembled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_r <= '0;
            acc_r <= '0;
        end else if (complete_s) begin
            idx_r <= '0;
        end else if (accept_s) begin
            idx_r                           <= idx_r + 3'd1;
            acc_r[idx_r*PIXEL_W +: PIXEL_W] <= bus.pixel_data;
        end
    end

    // Word and frame counters; the end-of-frame clear wins over the increment.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_count_r <= '0;
            word_count_r  <= 16'd0;
        end else if (send_s && bus.m_axis_tlast) begin
            frame_count_r <= frame_count_r + FRAME_CNT_W'(1);
            word_count_r  <= 16'd0;
        end else if (send_s) begin
            word_count_r  <= word_count_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench: two packers (pad 16'hFFFF and 16'h0000) share one stimulus stream.
module tb_pixel_word_packer;
    import pixel_pkg::*;

    typedef struct {
        pixel_t      data;
        logic        last;
        logic        expect_word;
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        logic        exp_last;
        logic [15:0] exp_wc;
        logic [15:0] exp_fc;
    } vec_t;

    logic   clk_in = 1'b0;
    logic   rst_in = 1'b1;
    logic   pixel_valid = 1'b0;
    pixel_t pixel_data = 16'h0000;
    logic   pixel_last = 1'b0;
    logic   tready = 1'b0;
    logic   prog_full = 1'b0;

    logic [15:0] fc_a, wc_a, fc_b, wc_b;
    int total = 0;
    int bad = 0;
    logic [128:0] q_a[$];
    logic [128:0] q_b[$];
    vec_t vecs[19];

    pixel_word_packer_if bus_a();
    pixel_word_packer_if bus_b();

    assign bus_a.pixel_valid      = pixel_valid;
    assign bus_a.pixel_data       = pixel_data;
    assign bus_a.pixel_last       = pixel_last;
    assign bus_a.m_axis_tready    = tready;
    assign bus_a.m_axis_prog_full = prog_full;
    assign bus_b.pixel_valid      = pixel_valid;
    assign bus_b.pixel_data       = pixel_data;
    assign bus_b.pixel_last       = pixel_last;
    assign bus_b.m_axis_tready    = tready;
    assign bus_b.m_axis_prog_full = prog_full;

    pixel_word_packer #(.PAD_VALUE(16'hFFFF), .FRAME_CNT_W(16)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_a.master),
        .frame_count(fc_a), .word_count(wc_a));

    pixel_word_packer #(.PAD_VALUE(16'h0000), .FRAME_CNT_W(16)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_b.master),
        .frame_count(fc_b), .word_count(wc_b));

    always #5 clk_in = ~clk_in;

    // Record every word that will be sent at the coming rising edge.
    always @(negedge clk_in) begin
        if (!rst_in && bus_a.m_axis_tvalid && tready) q_a.push_back({bus_a.m_axis_tlast, bus_a.m_axis_tdata});
        if (!rst_in && bus_b.m_axis_tvalid && tready) q_b.push_back({bus_b.m_axis_tlast, bus_b.m_axis_tdata});
    end

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present a pixel and wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic push(input pixel_t d, input logic l, output int cyc);
        pixel_valid = 1'b1;
        pixel_data  = d;
        pixel_last  = l;
        cyc = 0;
        #1;
        while (!bus_a.pixel_ready && cyc < 60) begin
            @(posedge clk_in); #1;
            cyc++;
        end
        if (!bus_a.pixel_ready) begin
            total++; bad++;
            $display("FAIL push_timeout: pixel %h not accepted after %0d cycles", d, cyc);
        end else begin
            @(posedge clk_in); #1;
            cyc++;
        end
    endtask

    task automatic idle_cycle();
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #1;
        chk("rst_ready",  {128'd0, bus_a.pixel_ready}, 129'd0);
        chk("rst_tvalid", {128'd0, bus_a.m_axis_tvalid}, 129'd0);
        chk("rst_tlast",  {128'd0, bus_a.m_axis_tlast}, 129'd0);
        chk("rst_tdata",  {1'b0, bus_a.m_axis_tdata}, 129'd0);
        chk("rst_fc",     {113'd0, fc_a}, 129'd0);
        chk("rst_wc",     {113'd0, wc_a}, 129'd0);
        repeat (2) @(posedge clk_in);
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        #3 rst_in = 1'b0;
        @(posedge clk_in); #1;
    endtask

    initial begin : main
        int cyc;
        int sum;
        // Test 1: pixels 1..8 in one frame; test 2: 11-pixel frame (counters are cumulative).
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{pixel_t'(i + 1), 1'b0, 1'b0, 128'd0, 128'd0, 1'b0, 16'd0, 16'd0};
        end
        vecs[7] = '{16'h0008, 1'b1, 1'b1,
                    128'h0008_0007_0006_0005_0004_0003_0002_0001,
                    128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1, 16'd0, 16'd1};
        for (int i = 0; i < 11; i++) begin
            vecs[8 + i] = '{pixel_t'(16'hA000 + i), 1'b0, 1'b0, 128'd0, 128'd0, 1'b0, 16'd0, 16'd0};
        end
        vecs[15] = '{16'hA007, 1'b0, 1'b1,
                     128'hA007_A006_A005_A004_A003_A002_A001_A000,
                     128'hA007_A006_A005_A004_A003_A002_A001_A000, 1'b0, 16'd1, 16'd1};
        vecs[18] = '{16'hA00A, 1'b1, 1'b1,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_A00A_A009_A008,
                     128'h0000_0000_0000_0000_0000_A00A_A009_A008, 1'b1, 16'd0, 16'd2};

        tready = 1'b1;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            push(vecs[i].data, vecs[i].last, cyc);
            if (vecs[i].expect_word) begin
                chk("tbl_tvalid", {128'd0, bus_a.m_axis_tvalid}, 129'd1);
                chk("tbl_tdata_a", {1'b0, bus_a.m_axis_tdata}, {1'b0, vecs[i].exp_a});
                chk("tbl_tdata_b", {1'b0, bus_b.m_axis_tdata}, {1'b0, vecs[i].exp_b});
                chk("tbl_tlast", {128'd0, bus_a.m_axis_tlast}, {128'd0, vecs[i].exp_last});
                idle_cycle();
                chk("tbl_wc", {113'd0, wc_a}, {113'd0, vecs[i].exp_wc});
                chk("tbl_fc", {113'd0, fc_a}, {113'd0, vecs[i].exp_fc});
                chk("tbl_drained", {128'd0, bus_a.m_axis_tvalid}, 129'd0);
            end
        end

        // Test 3: output stalled for 20 cycles, then free-flowing.
        do_reset();
        tready = 1'b0;
        q_a.delete();
        for (int i = 0; i < 8; i++) push(pixel_t'(16'hB000 + i), 1'b0, cyc);
        pixel_data = 16'hB008;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in); #1;
            chk("stall_ready", {128'd0, bus_a.pixel_ready}, 129'd0);
            chk("stall_tvalid", {128'd0, bus_a.m_axis_tvalid}, 129'd1);
            chk("stall_tdata", {bus_a.m_axis_tlast, bus_a.m_axis_tdata},
                {1'b0, 128'hB007_B006_B005_B004_B003_B002_B001_B000});
        end
        tready = 1'b1;
        sum = 0;
        for (int i = 8; i < 16; i++) begin
            push(pixel_t'(16'hB000 + i), (i == 15), cyc);
            sum += cyc;
        end
        chk("flow_cycles", 129'(sum), 129'd8);
        idle_cycle();
        chk("flow_words", 129'(q_a.size()), 129'd2);
        if (q_a.size() == 2) begin
            chk("flow_w0", q_a[0], {1'b0, 128'hB007_B006_B005_B004_B003_B002_B001_B000});
            chk("flow_w1", q_a[1], {1'b1, 128'hB00F_B00E_B00D_B00C_B00B_B00A_B009_B008});
        end

        // Test 4: prog_full blocks only the start of a word.
        do_reset();
        q_a.delete();
        prog_full   = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = 16'hC000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in); #1;
            chk("pf_idle_ready", {128'd0, bus_a.pixel_ready}, 129'd0);
        end
        chk("pf_idle_tvalid", {128'd0, bus_a.m_axis_tvalid}, 129'd0);
        prog_full = 1'b0;
        for (int i = 0; i < 3; i++) push(pixel_t'(16'hC000 + i), 1'b0, cyc);
        prog_full = 1'b1;
        sum = 0;
        for (int i = 3; i < 8; i++) begin
            push(pixel_t'(16'hC000 + i), 1'b0, cyc);
            sum += cyc;
        end
        chk("pf_finish_cycles", 129'(sum), 129'd5);
        chk("pf_word", {bus_a.m_axis_tlast, bus_a.m_axis_tdata},
            {1'b0, 128'hC007_C006_C005_C004_C003_C002_C001_C000});
        pixel_data = 16'hC008;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            chk("pf_hold_ready", {128'd0, bus_a.pixel_ready}, 129'd0);
        end
        chk("pf_hold_words", 129'(q_a.size()), 129'd1);
        prog_full = 1'b0;
        for (int i = 8; i < 16; i++) push(pixel_t'(16'hC000 + i), (i == 15), cyc);
        idle_cycle();
        chk("pf_words", 129'(q_a.size()), 129'd2);
        if (q_a.size() == 2) begin
            chk("pf_w1", q_a[1], {1'b1, 128'hC00F_C00E_C00D_C00C_C00B_C00A_C009_C008});
        end

        // Test 5: single-pixel frames, issued back to back.
        do_reset();
        q_b.delete();
        push(16'h1234, 1'b1, cyc);
        chk("single_b", {bus_b.m_axis_tlast, bus_b.m_axis_tdata}, {1'b1, 128'h1234});
        chk("single_a", {bus_a.m_axis_tlast, bus_a.m_axis_tdata},
            {1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1234});
        push(16'h1111, 1'b1, cyc);
        chk("b2b_cyc1", 129'(cyc), 129'd1);
        chk("b2b_tvalid1", {128'd0, bus_b.m_axis_tvalid}, 129'd1);
        chk("b2b_data1", {1'b0, bus_b.m_axis_tdata}, 129'h1111);
        push(16'h2222, 1'b1, cyc);
        chk("b2b_cyc2", 129'(cyc), 129'd1);
        chk("b2b_tvalid2", {128'd0, bus_b.m_axis_tvalid}, 129'd1);
        idle_cycle();
        chk("b2b_words", 129'(q_b.size()), 129'd3);
        if (q_b.size() == 3) begin
            chk("b2b_q0", q_b[0], {1'b1, 128'h1234});
            chk("b2b_q2", q_b[2], {1'b1, 128'h2222});
        end
        chk("b2b_fc", {113'd0, fc_b}, 129'd3);
        chk("b2b_wc", {113'd0, wc_b}, 129'd0);

        // Test 6: asynchronous reset with a stalled word, then mid-word.
        tready = 1'b0;
        for (int i = 0; i < 8; i++) push(pixel_t'(16'hD000 + i), 1'b0, cyc);
        chk("pre_rst_tvalid", {128'd0, bus_a.m_axis_tvalid}, 129'd1);
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 5; i++) push(pixel_t'(16'hD100 + i), 1'b0, cyc);
        do_reset();
        q_a.delete();
        for (int i = 0; i < 8; i++) push(pixel_t'(16'hE000 + i), (i == 7), cyc);
        chk("post_rst_word", {bus_a.m_axis_tlast, bus_a.m_axis_tdata},
            {1'b1, 128'hE007_E006_E005_E004_E003_E002_E001_E000});
        idle_cycle();
        chk("post_rst_fc", {113'd0, fc_a}, 129'd1);
        chk("post_rst_wc", {113'd0, wc_a}, 129'd0);
        chk("post_rst_words", 129'(q_a.size()), 129'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
